// File: rtl/adder_arb_pkg.sv
// Shared constants and FSM state type for the round-robin adder arbiter.
package adder_arb_pkg;

  localparam int W_DEF    = 3;
  localparam int NREQ_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/adder_core.sv
// W-bit ripple-carry adder assembled from full-adder bit slices; purely combinational.
module adder_core #(
  parameter int W = 3
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] carry_s;

  assign carry_s[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_slice
    // One full-adder slice: sum bit and carry into the next slice.
    assign sum[i]       = a[i] ^ b[i] ^ carry_s[i];
    assign carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
  end

  assign cout = carry_s[W];

endmodule

// File: rtl/tt_um_adder_arbiter.sv
// Round-robin arbiter that shares one adder core between NREQ requesters and
// returns a registered, ID-tagged result under a valid/ready handshake.
module tt_um_adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  input  logic [NREQ-1:0]   cin_in,
  output logic [NREQ-1:0]   gnt,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [W-1:0]      res_sum,
  output logic              res_cout,
  output logic [IDW-1:0]    res_id
);

  state_e            state_q, state_d;
  logic [IDW-1:0]    last_q, last_d;
  logic [W-1:0]      op_a_q, op_a_d;
  logic [W-1:0]      op_b_q, op_b_d;
  logic              op_cin_q, op_cin_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              res_valid_q, res_valid_d;
  logic [W-1:0]      res_sum_q, res_sum_d;
  logic              res_cout_q, res_cout_d;
  logic [IDW-1:0]    res_id_q, res_id_d;

  logic [IDW-1:0]    winner_s;
  logic [W-1:0]      core_sum_s;
  logic              core_cout_s;

  adder_core #(.W(W)) u_core (
    .a    (op_a_q),
    .b    (op_b_q),
    .cin  (op_cin_q),
    .sum  (core_sum_s),
    .cout (core_cout_s)
  );

  // Round-robin pick: first set req bit starting just after the last winner, wrapping.
  always_comb begin
    int  idx;
    logic found;
    winner_s = '0;
    found    = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end else begin
        idx = idx;
      end
      if (!found && req[idx]) begin
        winner_s = IDW'(idx);
        found    = 1'b1;
      end else begin
        found    = found;
      end
    end
  end

  // Next-state and next-register logic for the IDLE -> CALC -> RESP sequence.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_cin_d    = op_cin_q;
    gnt_d       = '0;
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    res_cout_d  = res_cout_q;
    res_id_d    = res_id_q;
    case (state_q)
      IDLE: begin
        if (req != '0) begin
          op_a_d   = a_in[winner_s*W +: W];
          op_b_d   = b_in[winner_s*W +: W];
          op_cin_d = cin_in[winner_s];
          gnt_d    = {{(NREQ-1){1'b0}}, 1'b1} << winner_s;
          last_d   = winner_s;
          state_d  = CALC;
        end else begin
          state_d  = IDLE;
        end
      end
      CALC: begin
        res_sum_d   = core_sum_s;
        res_cout_d  = core_cout_s;
        res_id_d    = last_q;
        res_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d     = RESP;
        end
      end
      default: begin
        res_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_q      <= IDW'(NREQ - 1);
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_cin_q    <= 1'b0;
      gnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_cout_q  <= 1'b0;
      res_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_cin_q    <= op_cin_d;
      gnt_q       <= gnt_d;
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_cout_q  <= res_cout_d;
      res_id_q    <= res_id_d;
    end
  end

  assign gnt       = gnt_q;
  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_cout  = res_cout_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_tt_um_adder_arbiter.sv
// Directed self-checking bench for tt_um_adder_arbiter.
module tb_tt_um_adder_arbiter;
  import adder_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 3;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ*W-1:0] b_in;
  logic [NREQ-1:0]   cin_in;
  logic [NREQ-1:0]   gnt;
  logic              res_valid;
  logic              res_ready;
  logic [W-1:0]      res_sum;
  logic              res_cout;
  logic [IDW-1:0]    res_id;

  int n_checks = 0;
  int n_errors = 0;

  tt_um_adder_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .cin_in    (cin_in),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .res_id    (res_id)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input int a, input int b, input int c);
    a_in[i*W +: W] = W'(a);
    b_in[i*W +: W] = W'(b);
    cin_in[i]      = c[0];
  endtask

  function automatic logic [31:0] state_now();
    return 32'(dut.state_q);
  endfunction

  // One complete transaction from a single requester with ready held high.
  task automatic run_one(input string tag, input int i, input int a, input int b, input int c,
                         input int esum, input int ecout);
    set_ops(i, a, b, c);
    req = 4'b0001 << i;
    tick();
    check_val({tag, "_gnt"}, 32'(gnt), 32'(4'b0001 << i));
    check_val({tag, "_valid_early"}, 32'(res_valid), 32'd0);
    req = 4'b0000;
    tick();
    check_val({tag, "_valid"}, 32'(res_valid), 32'd1);
    check_val({tag, "_gnt_off"}, 32'(gnt), 32'd0);
    check_val({tag, "_sum"}, 32'(res_sum), 32'(esum));
    check_val({tag, "_cout"}, 32'(res_cout), 32'(ecout));
    check_val({tag, "_id"}, 32'(res_id), 32'(i));
    tick();
    check_val({tag, "_valid_drop"}, 32'(res_valid), 32'd0);
    check_val({tag, "_sum_hold"}, 32'(res_sum), 32'(esum));
    check_val({tag, "_idle"}, state_now(), 32'(IDLE));
  endtask

  int exp_sum  [4] = '{1, 4, 5, 0};
  int exp_cout [4] = '{0, 0, 0, 1};
  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b0; req = '0; a_in = '0; b_in = '0; cin_in = '0; res_ready = 1'b1;
    tick(); tick();
    check_val("rst_gnt", 32'(gnt), 32'd0);
    check_val("rst_valid", 32'(res_valid), 32'd0);
    check_val("rst_sum", 32'(res_sum), 32'd0);
    check_val("rst_cout", 32'(res_cout), 32'd0);
    check_val("rst_id", 32'(res_id), 32'd0);
    check_val("rst_state", state_now(), 32'(IDLE));
    rst = 1'b1;
    tick();

    // Basic and overflow cases.
    run_one("single", 0, 3, 2, 1, 6, 0);
    run_one("ovf7", 2, 7, 7, 1, 7, 1);
    run_one("ovf4", 1, 4, 4, 0, 0, 1);

    // Fairness: all requesting from reset, grants 0,1,2,3,0 every 3 cycles.
    rst = 1'b0; tick(); rst = 1'b1;
    for (int i = 0; i < 4; i++) set_ops(i, i, i + 1, i & 1);
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      check_val($sformatf("fair_gnt%0d", g), 32'(gnt), 32'(4'b0001 << exp_order[g]));
      tick();
      check_val($sformatf("fair_gap%0d", g), 32'(gnt), 32'd0);
      check_val($sformatf("fair_id%0d", g), 32'(res_id), 32'(exp_order[g]));
      check_val($sformatf("fair_sum%0d", g), 32'(res_sum), 32'(exp_sum[exp_order[g]]));
      check_val($sformatf("fair_cout%0d", g), 32'(res_cout), 32'(exp_cout[exp_order[g]]));
      tick();
      check_val($sformatf("fair_gap2_%0d", g), 32'(gnt), 32'd0);
    end
    req = 4'b0000;
    tick();

    // Pointer at 1, req=1010 must grant 3.
    run_one("last1", 1, 2, 2, 0, 4, 0);
    set_ops(3, 6, 1, 1);
    req = 4'b1010;
    tick();
    check_val("rr_skip_gnt", 32'(gnt), 32'b1000);
    req = 4'b0000;
    tick();
    check_val("rr_skip_id", 32'(res_id), 32'd3);
    check_val("rr_skip_sum", 32'(res_sum), 32'd0);
    check_val("rr_skip_cout", 32'(res_cout), 32'd1);
    tick();

    // Backpressure: hold ready low 5 cycles in RESP, with a new request pending.
    set_ops(0, 5, 1, 0);
    res_ready = 1'b0;
    req = 4'b0001;
    tick();
    check_val("bp_gnt", 32'(gnt), 32'b0001);
    tick();
    for (int c = 0; c < 5; c++) begin
      check_val($sformatf("bp_valid%0d", c), 32'(res_valid), 32'd1);
      check_val($sformatf("bp_sum%0d", c), 32'(res_sum), 32'd6);
      check_val($sformatf("bp_id%0d", c), 32'(res_id), 32'd0);
      check_val($sformatf("bp_nognt%0d", c), 32'(gnt), 32'd0);
      if (c < 4) tick();
    end
    res_ready = 1'b1;
    req = 4'b0000;
    tick();
    check_val("bp_release_valid", 32'(res_valid), 32'd0);
    check_val("bp_release_idle", state_now(), 32'(IDLE));

    // Reset during CALC abandons the operation.
    set_ops(2, 3, 3, 0);
    req = 4'b0100;
    tick();
    check_val("mid_gnt", 32'(gnt), 32'b0100);
    rst = 1'b0;
    req = 4'b0000;
    tick();
    check_val("mid_valid", 32'(res_valid), 32'd0);
    check_val("mid_gnt_off", 32'(gnt), 32'd0);
    check_val("mid_sum", 32'(res_sum), 32'd0);
    check_val("mid_id", 32'(res_id), 32'd0);
    rst = 1'b1;
    tick();
    check_val("mid_after_valid", 32'(res_valid), 32'd0);
    check_val("mid_after_gnt", 32'(gnt), 32'd0);
    req = 4'b1111;
    tick();
    check_val("mid_next_lowest", 32'(gnt), 32'b0001);
    req = 4'b0000;
    tick(); tick();

    // Idle: nothing moves for 10 cycles.
    for (int c = 0; c < 10; c++) begin
      tick();
      check_val($sformatf("idle_gnt%0d", c), 32'(gnt), 32'd0);
      check_val($sformatf("idle_valid%0d", c), 32'(res_valid), 32'd0);
      check_val($sformatf("idle_state%0d", c), state_now(), 32'(IDLE));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
